// File: rtl/timer_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_bank: NCH independent programmable timers with sticky IRQs.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module timer_bank #(
  parameter int NCH            = 4,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = $clog2(NCH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [NCH-1:0]    irq
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam int               CH_W       = (ADDR_W > 2) ? ADDR_W - 2 : 1;

  logic [CH_W-1:0]  ch_sel;
  logic [1:0]       reg_sel;
  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] period_d [NCH];
  logic [CNT_W-1:0] count_q  [NCH];
  logic [CNT_W-1:0] count_d  [NCH];
  logic [NCH-1:0]   en_q, en_d, mode_q, mode_d, pend_q, pend_d;
  logic [NCH-1:0]   term;
  logic             unused_wdata;

  assign reg_sel      = addr[1:0];
  assign unused_wdata = ^wdata;
  assign irq          = pend_q;

  generate
    if (ADDR_W > 2) begin : g_ch_field
      assign ch_sel = addr[ADDR_W-1:2];
    end else begin : g_ch_single
      assign ch_sel = '0;
    end
  endgenerate

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    term     = '0;
    for (int c = 0; c < NCH; c++) begin
      term[c] = en_q[c] && (period_q[c] != '0) &&
                (count_q[c] == period_q[c] - CNT_W'(1));
      if (en_q[c] && (period_q[c] != '0)) begin
        count_d[c] = term[c] ? '0 : count_q[c] + CNT_W'(1);
      end
      if (term[c]) begin
        pend_d[c] = 1'b1;
        if (mode_q[c]) begin
          en_d[c] = 1'b0;
        end
      end
      if (we && (ch_sel == CH_W'(c))) begin
        case (reg_sel)
          2'd0: begin
            period_d[c] = wdata[CNT_W-1:0];
            count_d[c]  = '0;
          end
          2'd1: begin
            en_d[c]   = wdata[0];
            mode_d[c] = wdata[1];
            // A terminal on the same edge keeps PEND set over the W1C.
            if (wdata[2] && !term[c]) begin
              pend_d[c] = 1'b0;
            end
            if (wdata[0] && !en_q[c]) begin
              count_d[c] = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        period_q[c] <= RST_PERIOD;
        count_q[c]  <= '0;
      end
      en_q   <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel == CH_W'(c)) begin
        case (reg_sel)
          2'd0:    rdata[CNT_W-1:0] = period_q[c];
          2'd1:    rdata[2:0]       = {pend_q[c], mode_q[c], en_q[c]};
          2'd2:    rdata[CNT_W-1:0] = count_q[c];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
